unified_mem_hs: RTL and testbench

UNIFIED_MEM_HS -- requirements
Module: unified_mem_hs

---
 rtl/unified_mem_hs.sv | 106 ++++++++++
 tb/tb_unified_mem_hs.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_hs.sv
// Unified instruction/data memory: combinational instruction fetch port plus a
// handshaked data port with WAIT_STATES extra latency and error reporting.
module unified_mem_hs #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_adr,
  output logic [DATA_W-1:0] instruction,
  input  logic [ADDR_W-1:0] data_adr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] data_mem_out,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WAIT_L  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q;
  logic                rd_p0, wr_p0, err_q;
  logic [ADDR_W-1:0]   adr_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  logic req, take, commit, adr_ok, pc_ok, both;

  assign req    = mem_read | mem_write;
  assign take   = (state_q == S_IDLE) && req;
  assign commit = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign adr_ok = {1'b0, adr_p0} < DEPTH_L;
  assign pc_ok  = {1'b0, pc_adr} < DEPTH_L;
  assign both   = rd_p0 & wr_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 4'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_ready = (state_q == S_DONE);
    mem_err   = (state_q == S_DONE) && err_q;
  end

  // Request capture stage: control under reset, payload free-running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
      rd_p0 <= 1'b0;
      wr_p0 <= 1'b0;
    end else if (take) begin
      cnt_q <= WAIT_L;
      rd_p0 <= mem_read;
      wr_p0 <= mem_write;
    end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (take) begin
      adr_p0   <= data_adr;
      wdata_p0 <= write_data;
    end
  end

  // Access stage: everything below happens only on the edge entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q        <= 1'b0;
      data_mem_out <= '0;
    end else if (commit) begin
      err_q <= both | ~adr_ok;
      if (rd_p0 && !wr_p0)
        data_mem_out <= adr_ok ? mem[adr_p0[IDX_W-1:0]] : '0;
    end
  end

  // Array has no reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (commit && wr_p0 && !rd_p0 && adr_ok)
      mem[adr_p0[IDX_W-1:0]] <= wdata_p0;
  end

  assign instruction = pc_ok ? mem[pc_adr[IDX_W-1:0]] : '0;

endmodule

// File: tb/tb_unified_mem_hs.sv
// Directed bench: unit 0 runs WAIT_STATES=2 / DEPTH=512, unit 1 runs WAIT_STATES=0 / DEPTH=1024.
module tb_unified_mem_hs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd [2];
  logic        wr [2];
  logic [9:0]  adr [2];
  logic [9:0]  pc [2];
  logic [15:0] wd [2];
  logic [15:0] instr [2];
  logic [15:0] dout [2];
  logic        ready [2];
  logic        err [2];

  int total = 0;
  int bad   = 0;
  int lat;

  always #5 clk = ~clk;

  unified_mem_hs #(.DATA_W(16), .ADDR_W(10), .DEPTH(512), .WAIT_STATES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .pc_adr(pc[0]), .instruction(instr[0]),
    .data_adr(adr[0]), .write_data(wd[0]), .mem_read(rd[0]), .mem_write(wr[0]),
    .data_mem_out(dout[0]), .mem_ready(ready[0]), .mem_err(err[0])
  );

  unified_mem_hs #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024), .WAIT_STATES(0)) u_b (
    .clk(clk), .rst_n(rst_n), .pc_adr(pc[1]), .instruction(instr[1]),
    .data_adr(adr[1]), .write_data(wd[1]), .mem_read(rd[1]), .mem_write(wr[1]),
    .data_mem_out(dout[1]), .mem_ready(ready[1]), .mem_err(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request on unit u; lat = negedges from sampling edge until ready seen
  task automatic op(input int u, input logic r, input logic w, input logic [9:0] a,
                    input logic [15:0] d, output int l);
    @(negedge clk);
    rd[u] = r; wr[u] = w; adr[u] = a; wd[u] = d;
    @(negedge clk);
    rd[u] = 1'b0; wr[u] = 1'b0;
    l = 1;
    while (!ready[u] && l < 20) begin
      @(negedge clk);
      l++;
    end
  endtask

  int first_i, second_i, nstrobe;
  logic [15:0] d1, d2;

  initial begin
    for (int u = 0; u < 2; u++) begin
      rd[u] = 0; wr[u] = 0; adr[u] = '0; pc[u] = '0; wd[u] = '0;
    end
    #2;
    chk("rst_ready", ready[0], 1'b0);
    chk("rst_err", err[0], 1'b0);
    chk("rst_dout", dout[0], 16'h0);
    chk("rst_ready_b", ready[1], 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // setup stores on unit 0
    op(0, 0, 1, 10'd500, 16'h0001, lat);
    chk("st_lat", lat, 4);
    chk("st_err", err[0], 1'b0);
    op(0, 0, 1, 10'd7,   16'h1111, lat);
    op(0, 0, 1, 10'd3,   16'h3333, lat);
    op(0, 0, 1, 10'd9,   16'h5555, lat);
    op(0, 0, 1, 10'd88,  16'h0088, lat);

    // load latency
    op(0, 1, 0, 10'd500, 16'h0, lat);
    chk("ld_lat", lat, 4);
    chk("ld_data", dout[0], 16'h0001);
    chk("ld_err", err[0], 1'b0);
    @(negedge clk);
    chk("ld_ready_drop", ready[0], 1'b0);

    // store then fetch on the same address
    pc[0] = 10'd7;
    wr[0] = 1'b1; adr[0] = 10'd7; wd[0] = 16'hABCD;
    #1 chk("sf_pre", instr[0], 16'h1111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr[0] = 1'b0;
      chk("sf_old", instr[0], 16'h1111);
      chk("sf_notready", ready[0], 1'b0);
    end
    @(negedge clk);
    chk("sf_ready", ready[0], 1'b1);
    chk("sf_new", instr[0], 16'hABCD);
    op(0, 1, 0, 10'd7, 16'h0, lat);
    chk("sf_load", dout[0], 16'hABCD);

    // both strobes
    op(0, 1, 1, 10'd3, 16'hFFFF, lat);
    chk("both_ready", ready[0], 1'b1);
    chk("both_err", err[0], 1'b1);
    chk("both_dout", dout[0], 16'hABCD);
    pc[0] = 10'd3;
    #1 chk("both_mem", instr[0], 16'h3333);

    // out of range with DEPTH=512
    op(0, 1, 0, 10'd600, 16'h0, lat);
    chk("oor_ld_err", err[0], 1'b1);
    chk("oor_ld_dout", dout[0], 16'h0);
    op(0, 0, 1, 10'd600, 16'hDEAD, lat);
    chk("oor_st_err", err[0], 1'b1);
    pc[0] = 10'd88;
    #1 chk("oor_alias", instr[0], 16'h0088);
    pc[0] = 10'd600;
    #1 chk("oor_fetch", instr[0], 16'h0);

    // reset in the middle of a store
    op(0, 1, 0, 10'd500, 16'h0, lat);
    chk("pre_rst_dout", dout[0], 16'h0001);
    pc[0] = 10'd9;
    @(negedge clk);
    wr[0] = 1'b1; adr[0] = 10'd9; wd[0] = 16'h1234;
    @(negedge clk);
    wr[0] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready[0], 1'b0);
    chk("mid_rst_err", err[0], 1'b0);
    chk("mid_rst_dout", dout[0], 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_mem", instr[0], 16'h5555);
    op(0, 1, 0, 10'd9, 16'h0, lat);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_data", dout[0], 16'h5555);

    // zero wait states on unit 1
    op(1, 0, 1, 10'd500, 16'h0001, lat);
    chk("zw_st_lat", lat, 2);
    op(1, 0, 1, 10'd501, 16'h0002, lat);
    @(negedge clk);
    first_i = -1; second_i = -1; nstrobe = 0; d1 = '0; d2 = '0;
    rd[1] = 1'b1; adr[1] = 10'd500;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready[1]) begin
        nstrobe++;
        if (first_i < 0) begin first_i = i; d1 = dout[1]; end
        else if (second_i < 0) begin second_i = i; d2 = dout[1]; end
      end
      if (i == 1) adr[1] = 10'd501;
      if (i == 3) rd[1] = 1'b0;
    end
    chk("zw_first_at", first_i, 1);
    chk("zw_first_data", d1, 16'h0001);
    chk("zw_second_at", second_i, 4);
    chk("zw_second_data", d2, 16'h0002);
    chk("zw_strobes", nstrobe, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
